// File: rtl/adc_1bit.sv
// First-order sigma-delta ADC front end with second-order CIC decimator and signed PCM output.
// Optional DC-blocking high-pass after the scaler when ADC_1BIT_DCBLOCK_EN is defined.
module adc_1bit #(
    parameter int unsigned DIV       = 5,
    parameter int unsigned DECIM     = 64,
    parameter int unsigned BIT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic                 CMP_IN,
    output logic                 FB_OUT,
    output logic [BIT_WIDTH-1:0] SIGNAL,
    output logic                 VALID
);

    localparam int unsigned LOG2_DECIM = $clog2(DECIM);
    localparam int unsigned W          = 2 * LOG2_DECIM + 2;
    localparam int unsigned SHIFT      = BIT_WIDTH - 1 - 2 * LOG2_DECIM;
    localparam int unsigned SW         = BIT_WIDTH + 1;
    localparam int unsigned DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DEC_W      = LOG2_DECIM;

    localparam logic signed [SW-1:0] SAT_MAX = {2'b00, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {2'b11, {(BIT_WIDTH-1){1'b0}}};

    logic [DIV_W-1:0]     div_cnt;
    logic [DEC_W-1:0]     dec_cnt;
    logic [1:0]           settle_cnt;
    logic                 sync1;
    logic                 cmp_s;
    logic signed [W-1:0]  int1;
    logic signed [W-1:0]  int2;
    logic signed [W-1:0]  d1;
    logic signed [W-1:0]  d2;
    logic signed [W-1:0]  c2_q;
    logic                 c2_vld;

    logic                 tick_c;
    logic                 dec_wrap_c;
    logic signed [W-1:0]  x_c;
    logic signed [W-1:0]  c1_c;
    logic signed [W-1:0]  c2_c;
    logic signed [SW-1:0] wide_c;
    logic signed [BIT_WIDTH-1:0] sat_c;

    assign tick_c     = (div_cnt == DIV_W'(0));
    assign dec_wrap_c = tick_c && (dec_cnt == DEC_W'(DECIM - 1));
    assign x_c        = cmp_s ? W'(1) : {W{1'b1}};
    assign c1_c       = int2 - d1;
    assign c2_c       = c1_c - d2;

    // Scale the CIC result to full PCM range; only +DECIM^2 can exceed it.
    assign wide_c = SW'(c2_q) <<< SHIFT;
    always_comb begin
        sat_c = wide_c[BIT_WIDTH-1:0];
        if (wide_c > SAT_MAX) begin
            sat_c = SAT_MAX[BIT_WIDTH-1:0];
        end else if (wide_c < SAT_MIN) begin
            sat_c = SAT_MIN[BIT_WIDTH-1:0];
        end
    end

    // Synchronizer, tick divider, modulator, integrators and comb section.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            div_cnt    <= '0;
            dec_cnt    <= '0;
            settle_cnt <= '0;
            sync1      <= 1'b0;
            cmp_s      <= 1'b0;
            FB_OUT     <= 1'b0;
            int1       <= '0;
            int2       <= '0;
            d1         <= '0;
            d2         <= '0;
            c2_q       <= '0;
            c2_vld     <= 1'b0;
        end else begin
            sync1  <= CMP_IN;
            cmp_s  <= sync1;
            c2_vld <= 1'b0;
            div_cnt <= (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
            if (tick_c) begin
                FB_OUT  <= cmp_s;
                int1    <= int1 + x_c;
                int2    <= int2 + int1;
                dec_cnt <= dec_cnt + DEC_W'(1);
            end
            if (dec_wrap_c) begin
                d1   <= int2;
                d2   <= c1_c;
                c2_q <= c2_c;
                // Startup results are discarded until the comb delays hold real history.
                if (settle_cnt == 2'd2) begin
                    c2_vld <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt + 2'd1;
                end
            end
        end
    end

`ifdef ADC_1BIT_DCBLOCK_EN
    localparam int unsigned DW = BIT_WIDTH + 2;
    localparam logic signed [DW-1:0] DC_MAX = {3'b000, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [DW-1:0] DC_MIN = {3'b111, {(BIT_WIDTH-1){1'b0}}};

    logic signed [BIT_WIDTH-1:0] sc_q;
    logic signed [BIT_WIDTH-1:0] s_prev;
    logic signed [BIT_WIDTH-1:0] y_prev;
    logic                        sc_vld;
    logic signed [DW-1:0]        y_c;
    logic signed [BIT_WIDTH-1:0] y_sat_c;

    assign y_c = DW'(sc_q) - DW'(s_prev) + DW'(y_prev) - DW'(y_prev >>> 8);

    always_comb begin
        y_sat_c = y_c[BIT_WIDTH-1:0];
        if (y_c > DC_MAX) begin
            y_sat_c = DC_MAX[BIT_WIDTH-1:0];
        end else if (y_c < DC_MIN) begin
            y_sat_c = DC_MIN[BIT_WIDTH-1:0];
        end
    end

    // Scaler register followed by the one-pole DC blocker.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sc_q   <= '0;
            sc_vld <= 1'b0;
            s_prev <= '0;
            y_prev <= '0;
            SIGNAL <= '0;
            VALID  <= 1'b0;
        end else begin
            sc_vld <= c2_vld;
            VALID  <= sc_vld;
            if (c2_vld) begin
                sc_q <= sat_c;
            end
            if (sc_vld) begin
                SIGNAL <= y_sat_c;
                s_prev <= sc_q;
                y_prev <= y_sat_c;
            end
        end
    end
`else
    // Scaled CIC output straight to the port.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            SIGNAL <= '0;
            VALID  <= 1'b0;
        end else begin
            VALID <= c2_vld;
            if (c2_vld) begin
                SIGNAL <= sat_c;
            end
        end
    end
`endif

endmodule

// File: doc/adc_1bit.md
Name: adc_1bit

Overview:
- First-order sigma-delta ADC front end and second-order CIC decimator. Input is an external comparator; output is signed PCM.
- The block drives the RC integrator through FB_OUT, samples the comparator on CMP_IN, and decimates the bitstream to BIT_WIDTH-bit samples with a one-clock valid strobe.
- Used for audio/line-in capture. It is the receive-side counterpart of the 1-bit DAC and uses the same tick divider scheme.

Parameters:
- DIV, 5, modulator tick divider: one bitstream sample every DIV clocks (DIV >= 1).
- DECIM, 64, decimation ratio in ticks per output sample; power of two, 4..256.
- BIT_WIDTH, 16, output sample width (signed two's complement); 2*log2(DECIM) <= BIT_WIDTH-1 is required.

Ports:
- CLK  input  1  system clock.
- RESET_n  input  1  asynchronous active-low reset.
- CMP_IN  input  1  asynchronous comparator output (1 = input above integrator).
- FB_OUT  output  1  feedback bit to external RC network.
- SIGNAL  output  BIT_WIDTH  decimated signed sample.
- VALID  output  1  one-CLK pulse when SIGNAL updates.

Behaviour:
- Reset (async, RESET_n low): all state clears immediately. div_cnt, sync FFs, FB_OUT, integrators, comb delays, decimation counter, settle counter, SIGNAL and VALID all go to 0. Deasserting reset mid-operation restarts cleanly from this state.
- Divider: div_cnt counts 0..DIV-1 and wraps. A tick is the cycle where div_cnt==0.
- Sync: CMP_IN passes through a 2-FF synchronizer every clock, giving cmp_s.
- Modulator, on each tick:
  - FB_OUT <= cmp_s.
  - x = cmp_s ? +1 : -1.
  - int1 <= int1 + x; int2 <= int2 + int1 (uses the old int1).
- Widths: int1, int2, comb delays and comb outputs are all W = 2*log2(DECIM)+2 bits signed. Modular wrap-around is intentional and correct for CIC; do not saturate the integrators.
- Decimation: dec_cnt counts ticks 0..DECIM-1. On the tick where dec_cnt == DECIM-1:
  - c1 = int2 - d1, d1 <= int2.
  - c2 = c1 - d2, d2 <= c1.
  - c2 is registered as the CIC result; range is -DECIM^2..+DECIM^2.
- Scaling, in the cycle after the comb update:
  - SIGNAL <= c2 <<< (BIT_WIDTH-1-2*log2(DECIM)).
  - Saturate: +DECIM^2 maps to 2^(BIT_WIDTH-1)-1; -DECIM^2 maps exactly to -2^(BIT_WIDTH-1).
  - VALID pulses high for that one clock.
- Settling: the first 2 decimated results after reset are discarded. SIGNAL stays 0 and VALID stays low for them. A 2-bit settle counter saturates at 2.
- Timing: VALID rate is one pulse per DIV*DECIM clocks, exactly and jitter-free.
- Latency: a CMP_IN edge reaches cmp_s after 2 clocks and is consumed at the next tick.
- The tick and the decimation wrap coincide by construction. The integrator update and the comb read in the same cycle both use pre-tick register values.

Optional Feature:
- Macro ADC_1BIT_DCBLOCK_EN.
- When defined: a first-order DC-blocking high-pass follows the scaler, evaluated once per decimated sample.
  - y = s - s_prev + y_prev - (y_prev >>> 8).
  - Internal width BIT_WIDTH+2; result saturated to BIT_WIDTH.
  - s_prev and y_prev reset to 0 and are not updated during settling.
  - VALID is delayed by 1 additional clock.
- When undefined: SIGNAL is the scaled CIC output directly; no extra registers, no extra latency.

Test Plan:
- Reset check: hold RESET_n low, then release with CMP_IN=0 -> FB_OUT=0, SIGNAL=0, VALID low.
  - First VALID appears on the 3rd decimation boundary, 3*DIV*DECIM (=960) clocks plus pipeline after release.
- Full scale: CMP_IN held 1 with defaults -> steady SIGNAL = 32767 (saturated from +4096<<3).
  - CMP_IN held 0 -> SIGNAL = -32768.
  - FB_OUT follows CMP_IN two clocks plus up to DIV-1 clocks later.
- Mid-scale: CMP_IN toggled on every tick (1,0,1,0...) -> SIGNAL = 0 after settling; VALID period exactly 320 clocks.
- Closed loop: bench models the RC integrator (FB_OUT charges, comparator against a 25%-of-range DC level) -> SIGNAL settles to -16384 ±1 LSB·8.
  - With ADC_1BIT_DCBLOCK_EN, the same stimulus decays toward 0 and must fall below |256| within 2048 samples.
- Reset mid-operation: assert RESET_n low for one clock mid-decimation while full-scale -> SIGNAL and VALID go to 0 immediately.
  - The settle sequence restarts; no stale sample is emitted.
- Wrap-around: run 100000 decimated samples of a 1-in-4 ones pattern -> every sample = -16384 (integrator overflow invisible at the output).
